// File: rtl/alu_pipe_pkg.sv
// Shared opcode map and FSM state type for alu_pipe.
package alu_pipe_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;
  localparam logic [3:0] OP_IN  = 4'd12;

  typedef enum logic {S_RUN = 1'b0, S_MUL = 1'b1} state_t;
endpackage

// File: rtl/alu_pipe_shifter.sv
// Combinational barrel shifter; sel follows the low opcode bits: 0 SLL, 1 ROL, 2 SRL, 3 SRA.
module alu_pipe_shifter #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   amt,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);
  // amt==0 gives ramt==WIDTH, which shifts everything out, so ROL by 0 is a.
  logic [SHW:0] ramt;
  assign ramt = (SHW+1)'(WIDTH) - {1'b0, amt};

  always_comb begin
    y = '0;
    case (sel)
      2'd0:    y = a << amt;
      2'd1:    y = (a << amt) | (a >> ramt);
      2'd2:    y = a >> amt;
      default: y = $signed(a) >>> amt;
    endcase
  end
endmodule

// File: rtl/alu_pipe.sv
// Registered valid/ready ALU, one op in flight. Define ALU_PIPE_MUL_EN to build the
// iterative shift-add multiplier for opcode 7; otherwise opcode 7 behaves as reserved.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] dipswitch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wr_en,
  output logic             v,
  output logic             z,
  output logic             c,
  output logic             s,
  output logic             busy
);
  state_t           state;
  logic             accept, mul_go, mul_done, load_alu;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] shres, nres, mres;
  logic             nc, nv, nwr, mhi_nz;

  assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == S_MUL);
  assign load_alu = accept && !mul_go;

  alu_pipe_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shf (
    .a(in1), .amt(in2[SHW-1:0]), .sel(opcode[1:0]), .y(shres)
  );

  assign sum  = {1'b0, in1} + {1'b0, in2};
  assign diff = {1'b0, in1} - {1'b0, in2};

  always_comb begin
    nres = '0;
    nc   = 1'b0;
    nv   = 1'b0;
    nwr  = 1'b1;
    case (opcode)
      OP_ADD: begin
        nres = sum[WIDTH-1:0];
        nc   = sum[WIDTH];
        nv   = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        nres = diff[WIDTH-1:0];
        nc   = diff[WIDTH];
        nv   = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
        nwr  = (opcode != OP_CMP);
      end
      OP_AND: nres = in1 & in2;
      OP_OR:  nres = in1 | in2;
      OP_XOR: nres = in1 ^ in2;
      OP_MOV: nres = in1;
      OP_SLL, OP_ROL, OP_SRL, OP_SRA: nres = shres;
      OP_IN:  nres = dipswitch;
      default: nwr = 1'b0;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  state_t               state_nx;
  logic [2*WIDTH-1:0]   mcand, acc, acc_nx;
  logic [WIDTH-1:0]     mplier;
  logic [SHW-1:0]       cnt;

  assign mul_go   = accept && (opcode == OP_MUL);
  assign mul_done = (state == S_MUL) && (cnt == SHW'(WIDTH-1));
  assign acc_nx   = mplier[0] ? acc + mcand : acc;
  assign mres     = acc_nx[WIDTH-1:0];
  assign mhi_nz   = |acc_nx[2*WIDTH-1:WIDTH];

  always_comb begin
    state_nx = state;
    case (state)
      S_RUN:   if (mul_go)   state_nx = S_MUL;
      S_MUL:   if (mul_done) state_nx = S_RUN;
      default: state_nx = S_RUN;
    endcase
  end

  // One multiplier bit per cycle; the last step's sum goes straight to the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_RUN;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      if (mul_go) begin
        mcand  <= {{WIDTH{1'b0}}, in1};
        mplier <= in2;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == S_MUL) begin
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        acc    <= acc_nx;
        cnt    <= cnt + SHW'(1);
      end
    end
  end
`else
  assign state    = S_RUN;
  assign mul_go   = 1'b0;
  assign mul_done = 1'b0;
  assign mres     = '0;
  assign mhi_nz   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      wr_en     <= 1'b0;
      v         <= 1'b0;
      z         <= 1'b0;
      c         <= 1'b0;
      s         <= 1'b0;
    end else if (load_alu) begin
      out_valid <= 1'b1;
      result    <= nres;
      wr_en     <= nwr;
      v         <= nv;
      z         <= (nres == '0);
      c         <= nc;
      s         <= nres[WIDTH-1];
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mres;
      wr_en     <= 1'b1;
      v         <= 1'b0;
      z         <= (mres == '0);
      c         <= mhi_nz;
      s         <= mres[WIDTH-1];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
